// File: rtl/spi_reg_bridge_pkg.sv
// Shared types and word-field geometry for the SPI register bridge.
// Parity layout is selected by SPI_REG_BRIDGE_PARITY_EN.
package spi_reg_bridge_pkg;

    typedef enum logic [1:0] {IDLE, ARMED, SHIFT, COMMIT} state_e;

`ifdef SPI_REG_BRIDGE_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    function automatic int rw_pos(input int word_w);
        return word_w - 1;
    endfunction

    function automatic int addr_lsb(input int word_w, input int addr_w);
        return word_w - 1 - addr_w;
    endfunction

    function automatic int data_lsb();
        return PARITY_BITS;
    endfunction

    function automatic int data_width(input int word_w, input int addr_w);
        return word_w - 1 - addr_w - PARITY_BITS;
    endfunction

endpackage

// File: rtl/spi_reg_bridge_sync.sv
// Two-flop synchroniser bank with per-bit synchronous reset value.
module spi_reg_bridge_sync #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_reg_bridge.sv
// SPI mode-0 slave mapped onto a packed write/read register file, oversampled in clk_i.
// Define SPI_REG_BRIDGE_PARITY_EN to require odd parity in word bit 0.
module spi_reg_bridge
    import spi_reg_bridge_pkg::*;
#(
    parameter int  WORD_WIDTH  = 16,
    parameter int  ADDR_WIDTH  = 4,
    parameter int  NUM_WR_REGS = 8,
    parameter int  NUM_RD_REGS = 8,
    localparam int DATA_WIDTH  = data_width(WORD_WIDTH, ADDR_WIDTH)
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              spi_sck_i,
    input  logic                              spi_sdi_i,
    input  logic                              spi_cs_i,
    output logic                              spi_sdo_o,
    output logic [NUM_WR_REGS*DATA_WIDTH-1:0] wr_data_o,
    output logic [NUM_WR_REGS-1:0]            wr_strobe_o,
    input  logic [NUM_RD_REGS*DATA_WIDTH-1:0] rd_data_i,
    output logic [NUM_RD_REGS-1:0]            rd_strobe_o,
    output logic                              frame_err_o
);

    localparam int CNT_W    = $clog2(WORD_WIDTH + 1);
    localparam int RW_POS   = rw_pos(WORD_WIDTH);
    localparam int ADDR_LSB = addr_lsb(WORD_WIDTH, ADDR_WIDTH);
    localparam int DATA_LSB = data_lsb();
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(WORD_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WORD_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(2);

    logic cs_s, sck_s, sdi_s;
    logic cs_prev_q, sck_prev_q;
    logic sck_rise, sck_fall, cs_rise, cs_fall;

    state_e                            state_q, state_d;
    logic [CNT_W-1:0]                  bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0]             rx_sr_q, rx_sr_d;
    logic [WORD_WIDTH-1:0]             tx_sr_q, tx_sr_d;
    logic [WORD_WIDTH-1:0]             tx_buf_q, tx_buf_d;
    logic [NUM_WR_REGS*DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [NUM_WR_REGS-1:0]            wr_strobe_q, wr_strobe_d;
    logic [NUM_RD_REGS-1:0]            rd_strobe_q, rd_strobe_d;
    logic                              frame_err_q, frame_err_d;

    logic                  rx_rw;
    logic [ADDR_WIDTH-1:0] rx_addr;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  parity_ok;
    logic [WORD_WIDTH-1:0] resp;
    logic [DATA_WIDTH-1:0] rd_sel;
    int                    addr_idx;

    function automatic logic [WORD_WIDTH-1:0] with_parity(input logic [WORD_WIDTH-1:0] w);
`ifdef SPI_REG_BRIDGE_PARITY_EN
        return {w[WORD_WIDTH-1:1], ~(^w[WORD_WIDTH-1:1])};
`else
        return w;
`endif
    endfunction

    // CS resets high so a reset never looks like the start of a frame
    spi_reg_bridge_sync #(
        .WIDTH    (3),
        .RESET_VAL(3'b100)
    ) u_sync (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .d_i    ({spi_cs_i, spi_sck_i, spi_sdi_i}),
        .q_o    ({cs_s, sck_s, sdi_s})
    );

    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign cs_rise  = cs_s & ~cs_prev_q;
    assign cs_fall  = ~cs_s & cs_prev_q;

    assign rx_rw    = rx_sr_q[RW_POS];
    assign rx_addr  = rx_sr_q[ADDR_LSB +: ADDR_WIDTH];
    assign rx_data  = rx_sr_q[DATA_LSB +: DATA_WIDTH];
    assign addr_idx = int'(rx_addr);
`ifdef SPI_REG_BRIDGE_PARITY_EN
    assign parity_ok = ^rx_sr_q;
`else
    assign parity_ok = 1'b1;
`endif

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        tx_buf_d    = tx_buf_q;
        wr_data_d   = wr_data_q;
        wr_strobe_d = '0;
        rd_strobe_d = '0;
        frame_err_d = 1'b0;
        resp        = '0;
        rd_sel      = '0;
        case (state_q)
            // The synchroniser shows its reset value (CS high) for two cycles,
            // so CS must read high on a third consecutive cycle before arming.
            IDLE: begin
                if (!cs_s) begin
                    bit_cnt_d = '0;
                end else if (bit_cnt_q == CNT_SETTLE) begin
                    bit_cnt_d = '0;
                    state_d   = ARMED;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
            end
            ARMED: begin
                if (cs_fall) begin
                    tx_sr_d   = tx_buf_q;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_d = ARMED;
                end else if (sck_rise) begin
                    rx_sr_d   = {rx_sr_q[WORD_WIDTH-2:0], sdi_s};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_d == CNT_FULL) state_d = COMMIT;
                end else if (sck_fall && bit_cnt_q != '0 && bit_cnt_q <= CNT_LAST) begin
                    tx_sr_d = {tx_sr_q[WORD_WIDTH-2:0], 1'b0};
                end
            end
            COMMIT: begin
                resp[RW_POS]                 = rx_rw;
                resp[ADDR_LSB +: ADDR_WIDTH] = rx_addr;
                if (parity_ok && rx_rw && addr_idx < NUM_WR_REGS) begin
                    wr_data_d[addr_idx*DATA_WIDTH +: DATA_WIDTH] = rx_data;
                    wr_strobe_d[addr_idx]                        = 1'b1;
                    resp[DATA_LSB +: DATA_WIDTH]                 = rx_data;
                    tx_buf_d                                     = with_parity(resp);
                end else if (parity_ok && !rx_rw && addr_idx < NUM_RD_REGS) begin
                    rd_sel                       = rd_data_i[addr_idx*DATA_WIDTH +: DATA_WIDTH];
                    rd_strobe_d[addr_idx]        = 1'b1;
                    resp[DATA_LSB +: DATA_WIDTH] = rd_sel;
                    tx_buf_d                     = with_parity(resp);
                end else begin
                    frame_err_d = 1'b1;
                    tx_buf_d    = with_parity('1);
                end
                tx_sr_d   = tx_buf_d;
                bit_cnt_d = '0;
                state_d   = cs_s ? ARMED : SHIFT;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '0;
            tx_buf_q    <= '0;
            wr_data_q   <= '0;
            wr_strobe_q <= '0;
            rd_strobe_q <= '0;
            frame_err_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            sck_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            tx_buf_q    <= tx_buf_d;
            wr_data_q   <= wr_data_d;
            wr_strobe_q <= wr_strobe_d;
            rd_strobe_q <= rd_strobe_d;
            frame_err_q <= frame_err_d;
            cs_prev_q   <= cs_s;
            sck_prev_q  <= sck_s;
        end
    end

    assign spi_sdo_o   = tx_sr_q[WORD_WIDTH-1] & ~spi_cs_i
                         & (state_q == SHIFT || state_q == COMMIT);
    assign wr_data_o   = wr_data_q;
    assign wr_strobe_o = wr_strobe_q;
    assign rd_strobe_o = rd_strobe_q;
    assign frame_err_o = frame_err_q;

endmodule
